// File: rtl/irq_pending_ctrl_if.sv
// Valid/ack handshake that offers one serviced interrupt index to the consumer.
`timescale 1ns/1ps
interface irq_pending_ctrl_if;
   logic       irq_valid;
   logic [2:0] irq_id;
   logic       irq_ack;

   modport master (output irq_valid, output irq_id, input irq_ack);
   modport slave  (input irq_valid, input irq_id, output irq_ack);
endinterface

// File: rtl/irq_pending_ctrl.sv
// Pending-request latch and valid/ack front-end feeding an external 8:3 priority encoder.
// Build option EDGE_DETECT_EN: pend is set on a 0->1 req transition instead of on req level.
`timescale 1ns/1ps
module irq_pending_ctrl #(
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 15
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [7:0]         i_req,
   input  logic [7:0]         i_mask,
   output logic [7:0]         o_pend,
   input  logic [2:0]         i_enc_xin,
   input  logic               i_enc_v,
   irq_pending_ctrl_if.master irq_if,
   output logic               o_timeout_err,
   output logic [CNT_W-1:0]   o_svc_cnt
);
   typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t           r_state;
   logic [7:0]       r_pend;
   logic [7:0]       r_timer;
   logic             r_valid;
   logic [2:0]       r_id;
   logic             r_terr;
   logic [CNT_W-1:0] r_svc;

   logic [7:0]       w_set;
   logic [7:0]       w_clr;
   logic             w_ack;

`ifdef EDGE_DETECT_EN
   logic [7:0] r_req_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_req_q <= '0;
      else       r_req_q <= i_req;
   end

   assign w_set = i_req & ~r_req_q;
`else
   assign w_set = i_req;
`endif

   assign w_ack = (r_state == BUSY) && irq_if.irq_ack;
   assign w_clr = w_ack ? (8'd1 << r_id) : 8'd0;

   // Clear applied before set, so a same-cycle set on the serviced bit wins.
   always_ff @(posedge i_clk) begin
      if (i_rst) r_pend <= '0;
      else       r_pend <= (r_pend & ~w_clr) | (w_set & ~i_mask);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_timer <= '0;
         r_valid <= 1'b0;
         r_id    <= '0;
         r_terr  <= 1'b0;
         r_svc   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_enc_v) begin
                  r_id    <= i_enc_xin;
                  r_valid <= 1'b1;
                  r_timer <= '0;
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               if (irq_if.irq_ack) begin
                  r_valid <= 1'b0;
                  r_svc   <= r_svc + 1'b1;
                  r_state <= GAP;
               end else if (r_timer == TMO_LAST) begin
                  r_valid <= 1'b0;
                  r_terr  <= 1'b1;
                  r_state <= GAP;
               end else begin
                  r_timer <= r_timer + 8'd1;
               end
            end
            GAP: begin
               // Lets the encoder settle on the post-clear pend before IDLE samples it.
               r_terr  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_pend           = r_pend;
   assign irq_if.irq_valid = r_valid;
   assign irq_if.irq_id    = r_id;
   assign o_timeout_err    = r_terr;
   assign o_svc_cnt        = r_svc;
endmodule
